snake_dir_ctrl: RTL and testbench

Consumes the single-cycle key pulses produced by the debouncer and converts them into the snake's registered heading, applied only on game-step ticks. A small turn queue buffers up to QDEPTH accepted turns between ticks, so fast double taps (e.g. up then left inside one step) are not lost. The block rejects 180° reversals and redundant turns. It sits between the debouncer and the snake movement/position logic.

---
 rtl/snake_dir_ctrl_pkg.sv | 21 ++
 rtl/snake_dir_ctrl_if.sv | 25 ++
 rtl/snake_dir_ctrl_fifo.sv | 58 +++++
 rtl/snake_dir_ctrl.sv | 94 +++++++++
 tb/tb_snake_dir_ctrl.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/snake_dir_ctrl_pkg.sv
// Shared definitions for the snake heading controller.
//   - dir_e            : 2-bit heading encoding (UP, RIGHT, DOWN, LEFT)
//   - INIT_DIR_DEFAULT : heading after reset or a new game
//   - opposite()       : the 180-degree reversal of a heading
package snake_defs;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_e;

  localparam logic [1:0] INIT_DIR_DEFAULT = DIR_RIGHT;

  // Headings are laid out clockwise, so flipping bit 1 reverses them.
  function automatic logic [1:0] opposite(input logic [1:0] d);
    return d ^ 2'd2;
  endfunction

endpackage

// File: rtl/snake_dir_ctrl_if.sv
// Key/tick/clear inputs and heading outputs of snake_dir_ctrl.
//   master : drives keys, tick, clear; observes dir, turned, drop, q_count
//   slave  : the controller itself
interface snake_dir_ctrl_if;
  logic       X0_deb;
  logic       X1_deb;
  logic       X2_deb;
  logic       X3_deb;
  logic       tick;
  logic       clear;
  logic [1:0] dir;
  logic       turned;
  logic       drop;
  logic [2:0] q_count;

  modport master (
    output X0_deb, X1_deb, X2_deb, X3_deb, tick, clear,
    input  dir, turned, drop, q_count
  );

  modport slave (
    input  X0_deb, X1_deb, X2_deb, X3_deb, tick, clear,
    output dir, turned, drop, q_count
  );
endinterface

// File: rtl/snake_dir_ctrl_fifo.sv
// snake_dir_fifo: QDEPTH-entry circular buffer of 2-bit headings.
//   VGA_CLK, reset_n : clock, async active-low reset
//   flush            : synchronous empty (wins over push/pop)
//   push, din        : write din at the tail
//   pop              : discard the head entry
//   head, tail       : oldest and newest entries (valid when count > 0)
//   count            : number of entries, 0..QDEPTH
// Push while full is honoured only together with a pop.
module snake_dir_fifo #(
  parameter int QDEPTH = 2
) (
  input  logic       VGA_CLK,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] din,
  output logic [1:0] head,
  output logic [1:0] tail,
  output logic [2:0] count
);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(QDEPTH - 1);

  logic [1:0]    mem [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] tail_ptr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign tail_ptr = (wr_ptr == '0) ? LAST : wr_ptr - PW'(1);
  assign head     = mem[rd_ptr];
  assign tail     = mem[tail_ptr];

  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < QDEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + 3'd1;
      else if (pop && !push) count <= count - 3'd1;
    end
  end
endmodule

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: turns debounced key pulses into the snake heading.
//   VGA_CLK, reset_n : clock, async active-low reset
//   bus (slave)      : X0..X3_deb key pulses (UP/RIGHT/DOWN/LEFT), tick,
//                      clear; outputs dir, turned, drop, q_count
// Accepted turns wait in a small queue and are applied one per tick.
module snake_dir_ctrl
  import snake_defs::*;
#(
  parameter int         QDEPTH   = 2,
  parameter logic [1:0] INIT_DIR = INIT_DIR_DEFAULT
) (
  input  logic            VGA_CLK,
  input  logic            reset_n,
  snake_dir_ctrl_if.slave bus
);
  logic [3:0] keys;
  logic [2:0] key_cnt;
  logic [1:0] key_code;
  logic       req;
  logic       multi;
  logic [1:0] dir_q;
  logic [1:0] ref_dir;
  logic [1:0] q_head;
  logic [1:0] q_tail;
  logic [2:0] q_cnt;
  logic       q_empty;
  logic       has_space;
  logic       accept;
  logic       pop;
  logic       bypass;
  logic       push;
  logic       turned_q;
  logic       drop_q;

  assign keys = {bus.X3_deb, bus.X2_deb, bus.X1_deb, bus.X0_deb};

  always_comb begin
    key_cnt  = '0;
    key_code = '0;
    for (int i = 0; i < 4; i++) begin
      if (keys[i]) begin
        key_cnt  = key_cnt + 3'd1;
        key_code = 2'(i);
      end
    end
  end

  assign req     = (key_cnt == 3'd1);
  assign multi   = (key_cnt > 3'd1);
  assign q_empty = (q_cnt == '0);

  // New turns are judged against where the snake will be heading once
  // everything already queued has been applied.
  assign ref_dir   = q_empty ? dir_q : q_tail;
  // A full queue still takes a turn when this tick pops the head.
  assign has_space = (q_cnt < 3'(QDEPTH)) || bus.tick;
  assign accept    = req && !bus.clear && has_space &&
                     (key_code != ref_dir) && (key_code != opposite(ref_dir));

  assign pop    = bus.tick && !q_empty && !bus.clear;
  assign bypass = bus.tick && q_empty && accept;
  assign push   = accept && !bypass;

  snake_dir_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .VGA_CLK (VGA_CLK),
    .reset_n (reset_n),
    .flush   (bus.clear),
    .push    (push),
    .pop     (pop),
    .din     (key_code),
    .head    (q_head),
    .tail    (q_tail),
    .count   (q_cnt)
  );

  always_ff @(posedge VGA_CLK or negedge reset_n) begin
    if (!reset_n) begin
      dir_q    <= INIT_DIR;
      turned_q <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      if (bus.clear)   dir_q <= INIT_DIR;
      else if (pop)    dir_q <= q_head;
      else if (bypass) dir_q <= key_code;
      turned_q <= pop || bypass;
      drop_q   <= !bus.clear && (multi || (req && !accept));
    end
  end

  assign bus.dir     = dir_q;
  assign bus.turned  = turned_q;
  assign bus.drop    = drop_q;
  assign bus.q_count = q_cnt;
endmodule

// File: tb/tb_snake_dir_ctrl.sv
module tb_snake_dir_ctrl;
  import snake_defs::*;

  localparam int QD = 2;
  localparam int INIT = 1;

  typedef struct {
    logic [1:0] dir;
    logic       turned;
    logic       drop;
    logic [2:0] qc;
  } exp_t;

  logic VGA_CLK = 1'b0;
  logic reset_n = 1'b1;
  always #5 VGA_CLK = ~VGA_CLK;

  snake_dir_ctrl_if bus();

  snake_dir_ctrl #(.QDEPTH(QD), .INIT_DIR(2'(INIT))) dut (
    .VGA_CLK (VGA_CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  // Reference model: plain heading plus a list of pending turns.
  int m_dir = INIT;
  int m_q[$];

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
    end
  endtask

  function automatic exp_t model_step(input logic [3:0] keys, input logic tick,
                                      input logic clr);
    exp_t e;
    int   n = $countones(keys);
    int   code = 0;
    int   refd;
    bit   ok;
    for (int i = 0; i < 4; i++) if (keys[i]) code = i;
    e.turned = 1'b0;
    e.drop   = 1'b0;
    if (clr) begin
      m_q.delete();
      m_dir = INIT;
    end else begin
      refd = (m_q.size() > 0) ? m_q[$] : m_dir;
      ok = (n == 1) && (code != refd) && (code != (refd ^ 2)) &&
           ((m_q.size() < QD) || tick);
      e.drop = (n > 1) || ((n == 1) && !ok);
      if (tick && m_q.size() > 0) begin
        m_dir = m_q.pop_front();
        e.turned = 1'b1;
        if (ok) m_q.push_back(code);
      end else if (tick && ok) begin
        m_dir = code;
        e.turned = 1'b1;
      end else if (ok) begin
        m_q.push_back(code);
      end
    end
    e.dir = m_dir[1:0];
    e.qc  = 3'(m_q.size());
    return e;
  endfunction

  task automatic set_inputs(input logic [3:0] keys, input logic tick, input logic clr);
    bus.X0_deb = keys[0];
    bus.X1_deb = keys[1];
    bus.X2_deb = keys[2];
    bus.X3_deb = keys[3];
    bus.tick   = tick;
    bus.clear  = clr;
  endtask

  task automatic drive(input logic [3:0] keys, input logic tick, input logic clr);
    @(negedge VGA_CLK);
    set_inputs(keys, tick, clr);
    sb.push_back(model_step(keys, tick, clr));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_dir"},    int'(bus.dir),     INIT);
    check({tag, "_qc"},     int'(bus.q_count), 0);
    check({tag, "_turned"}, int'(bus.turned),  0);
    check({tag, "_drop"},   int'(bus.drop),    0);
  endtask

  // Waits (bounded) until every queued expectation has been compared.
  task automatic drain(input string tag);
    int k = 0;
    while (sb.size() > 0 && k < 20) begin
      @(posedge VGA_CLK);
      #3;
      k++;
    end
    check({tag, "_drain_pending"}, sb.size(), 0);
  endtask

  // Monitor: every cycle the DUT presents a fresh registered result.
  initial begin
    exp_t e;
    forever begin
      @(posedge VGA_CLK);
      #2;
      if (reset_n && sb.size() > 0) begin
        e = sb.pop_front();
        check("dir",     int'(bus.dir),     int'(e.dir));
        check("turned",  int'(bus.turned),  int'(e.turned));
        check("drop",    int'(bus.drop),    int'(e.drop));
        check("q_count", int'(bus.q_count), int'(e.qc));
      end
    end
  end

  initial begin
    logic [3:0] rk;
    set_inputs(4'b0000, 1'b0, 1'b0);
    #1 reset_n = 1'b0;
    #2 check_reset_outputs("por");
    @(negedge VGA_CLK);
    @(negedge VGA_CLK);
    reset_n = 1'b1;

    // Queued DOWN applied on the next tick.
    drive(4'b0100, 0, 0);
    drive(4'b0000, 1, 0);
    drive(4'b0000, 0, 1);
    // Reversal and same-direction presses are dropped.
    drive(4'b1000, 0, 0);
    drive(4'b0010, 0, 0);
    // Double tap UP then LEFT, applied one per tick.
    drive(4'b0001, 0, 0);
    drive(4'b1000, 0, 0);
    drive(4'b0000, 1, 0);
    drive(4'b0000, 1, 0);
    drive(4'b0000, 1, 0);
    drive(4'b0000, 0, 1);
    // Full queue: press without tick dropped, press with tick accepted.
    drive(4'b0001, 0, 0);
    drive(4'b1000, 0, 0);
    drive(4'b0100, 0, 0);
    drive(4'b0100, 1, 0);
    drive(4'b0000, 1, 0);
    drive(4'b0000, 1, 0);
    drive(4'b0000, 0, 1);
    // Bypass on tick with empty queue; simultaneous keys dropped.
    drive(4'b0001, 1, 0);
    drive(4'b0000, 0, 1);
    drive(4'b0101, 0, 0);
    // Clear with two queued entries.
    drive(4'b0001, 0, 0);
    drive(4'b1000, 0, 0);
    drive(4'b0000, 0, 1);
    // Async reset mid-queue, asserted between edges.
    drive(4'b0001, 0, 0);
    drive(4'b1000, 0, 0);
    drive(4'b0000, 0, 0);
    drain("pre_reset");
    set_inputs(4'b0000, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    m_q.delete();
    m_dir = INIT;
    @(negedge VGA_CLK);
    reset_n = 1'b1;
    drive(4'b0000, 1, 0);
    drive(4'b0000, 1, 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      int r = $urandom_range(0, 9);
      if (r < 5)      rk = 4'b0000;
      else if (r < 9) rk = 4'b0001 << $urandom_range(0, 3);
      else            rk = 4'($urandom);
      drive(rk, $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
    end
    drive(4'b0000, 0, 0);
    drain("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
